// File: rtl/msg_slot_pkg.sv
// Shared types for the message-slot scheduler: slot lifecycle states,
// error codes and the ready-queue entry layout.
package msg_slot_pkg;

  localparam int PKG_TAG_W  = 4;
  localparam int PKG_ADDR_W = 10;
  localparam int BEATS_W    = 8;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_READY   = 2'd2,
    SLOT_READING = 2'd3
  } slot_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_DUP_ALLOC = 2'd1;
  localparam logic [1:0] ERR_BAD_CMPL  = 2'd2;
  localparam logic [1:0] ERR_BAD_REL   = 2'd3;

  // Field widths follow the default tag/address widths of the scheduler.
  typedef struct packed {
    logic [PKG_TAG_W-1:0]  tag;
    logic [PKG_ADDR_W-1:0] base;
    logic [BEATS_W-1:0]    beats;
  } rdy_entry_t;

endpackage

// File: rtl/msg_slot_sched_if.sv
// Request/response bundle between the message receiver, the read path and
// the slot scheduler.
interface msg_slot_sched_if
  import msg_slot_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_W      = 4
);
  logic                         alloc_valid;
  logic [TAG_W-1:0]             alloc_tag;
  logic                         alloc_ready;
  logic                         alloc_done;
  logic [ADDR_WIDTH-1:0]        alloc_base;
  logic                         cmpl_valid;
  logic [TAG_W-1:0]             cmpl_tag;
  logic [BEATS_W-1:0]           cmpl_beats;
  logic                         rd_valid;
  logic                         rd_ready;
  logic [TAG_W-1:0]             rd_tag;
  logic [ADDR_WIDTH-1:0]        rd_base;
  logic [BEATS_W-1:0]           rd_beats;
  logic                         rel_valid;
  logic [TAG_W-1:0]             rel_tag;
  logic                         err;
  logic [1:0]                   err_code;
  logic [$clog2(NUM_SLOTS):0]   free_cnt;

  modport master (
    output alloc_valid, alloc_tag, cmpl_valid, cmpl_tag, cmpl_beats,
           rd_ready, rel_valid, rel_tag,
    input  alloc_ready, alloc_done, alloc_base, rd_valid, rd_tag, rd_base,
           rd_beats, err, err_code, free_cnt
  );

  modport slave (
    input  alloc_valid, alloc_tag, cmpl_valid, cmpl_tag, cmpl_beats,
           rd_ready, rel_valid, rel_tag,
    output alloc_ready, alloc_done, alloc_base, rd_valid, rd_tag, rd_base,
           rd_beats, err, err_code, free_cnt
  );
endinterface

// File: rtl/msg_slot_fifo.sv
// Synchronous FIFO with count-based full/empty; the head word is read
// combinationally through a registered read pointer.
module msg_slot_fifo
  import msg_slot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/msg_slot_sched.sv
// Slot scheduler for the message-assembly SRAM: allocates a slot per tag,
// queues completed messages for the reader and recycles released slots.
module msg_slot_sched
  import msg_slot_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_BEATS = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_W      = 4
) (
  input logic             clk,
  input logic             rst,
  msg_slot_sched_if.slave bus
);
  localparam int SLOT_W   = $clog2(NUM_SLOTS);
  localparam int CNT_W    = SLOT_W + 1;
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int BEAT_SH  = $clog2(SLOT_BEATS);
  localparam logic [BEATS_W-1:0] MAX_BEATS = BEATS_W'(SLOT_BEATS);

  function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_W-1:0] idx);
    return ADDR_WIDTH'(idx) << BEAT_SH;
  endfunction

  slot_state_e       slot_st [NUM_SLOTS];
  logic [NUM_TAGS-1:0] tag_vld;
  logic [SLOT_W-1:0] tag_slot [NUM_TAGS];
  logic [CNT_W-1:0]  free_cnt_q;

  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              alloc_ready_int;
  logic              alloc_acc, alloc_dup, alloc_grant;
  logic [SLOT_W-1:0] cmpl_slot, rel_slot, pop_slot;
  logic              cmpl_ok, cmpl_bad, rel_ok, rel_bad;
  logic              rd_valid_int, rd_pop;
  logic              fifo_full, fifo_empty;
  rdy_entry_t        head;
  rdy_entry_t        entry_p1;
  logic              vld_p1;

  // Lowest-index free slot, from start-of-cycle state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && slot_st[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  assign alloc_ready_int = !rst && (free_cnt_q != '0);
  assign alloc_acc   = bus.alloc_valid && alloc_ready_int;
  assign alloc_dup   = alloc_acc && tag_vld[bus.alloc_tag];
  assign alloc_grant = alloc_acc && !tag_vld[bus.alloc_tag] && free_found;

  assign cmpl_slot = tag_slot[bus.cmpl_tag];
  assign cmpl_ok   = bus.cmpl_valid && tag_vld[bus.cmpl_tag] &&
                     (slot_st[cmpl_slot] == SLOT_FILLING) &&
                     (bus.cmpl_beats != '0) && (bus.cmpl_beats <= MAX_BEATS) &&
                     !fifo_full;
  assign cmpl_bad  = bus.cmpl_valid && !cmpl_ok;

  assign rel_slot = tag_slot[bus.rel_tag];
  assign rel_ok   = bus.rel_valid && tag_vld[bus.rel_tag] &&
                    (slot_st[rel_slot] == SLOT_READING);
  assign rel_bad  = bus.rel_valid && !rel_ok;

  assign rd_valid_int = !rst && !fifo_empty;
  assign rd_pop       = rd_valid_int && bus.rd_ready;
  assign pop_slot     = SLOT_W'(head.base >> BEAT_SH);

  assign bus.alloc_ready = alloc_ready_int;
  assign bus.free_cnt    = free_cnt_q;
  assign bus.rd_valid    = rd_valid_int;
  assign bus.rd_tag      = rd_valid_int ? head.tag   : '0;
  assign bus.rd_base     = rd_valid_int ? head.base  : '0;
  assign bus.rd_beats    = rd_valid_int ? head.beats : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_st[i] <= SLOT_FREE;
      tag_vld        <= '0;
      free_cnt_q     <= CNT_W'(NUM_SLOTS);
      vld_p1         <= 1'b0;
      bus.alloc_done <= 1'b0;
      bus.alloc_base <= '0;
      bus.err        <= 1'b0;
      bus.err_code   <= ERR_NONE;
    end else begin
      if (alloc_grant) begin
        slot_st[free_idx]      <= SLOT_FILLING;
        tag_vld[bus.alloc_tag] <= 1'b1;
        bus.alloc_base         <= slot_base(free_idx);
      end
      if (cmpl_ok) slot_st[cmpl_slot] <= SLOT_READY;
      if (rd_pop)  slot_st[pop_slot]  <= SLOT_READING;
      if (rel_ok) begin
        slot_st[rel_slot]    <= SLOT_FREE;
        tag_vld[bus.rel_tag] <= 1'b0;
      end
      free_cnt_q     <= free_cnt_q - CNT_W'(alloc_grant) + CNT_W'(rel_ok);
      vld_p1         <= cmpl_ok;
      bus.alloc_done <= alloc_grant;
      bus.err        <= alloc_dup || cmpl_bad || rel_bad;
      bus.err_code   <= alloc_dup ? ERR_DUP_ALLOC :
                        cmpl_bad  ? ERR_BAD_CMPL  :
                        rel_bad   ? ERR_BAD_REL   : ERR_NONE;
    end
  end

  // Stage p1: completed entry waits one cycle before entering the queue.
  always_ff @(posedge clk) begin
    if (alloc_grant) tag_slot[bus.alloc_tag] <= free_idx;
    if (cmpl_ok) begin
      entry_p1.tag   <= bus.cmpl_tag;
      entry_p1.base  <= slot_base(cmpl_slot);
      entry_p1.beats <= bus.cmpl_beats;
    end
  end

  msg_slot_fifo #(
    .WIDTH ($bits(rdy_entry_t)),
    .DEPTH (NUM_SLOTS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .din   (entry_p1),
    .pop   (rd_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_msg_slot_sched.sv
// Scenario bench for msg_slot_sched: expected grants, queue entries and
// error codes are queued when stimulus is driven and popped when observed.
module tb_msg_slot_sched;
  import msg_slot_pkg::*;

  typedef struct packed {
    logic [3:0] tag;
    logic [9:0] base;
    logic [7:0] beats;
  } exp_rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [9:0] alloc_q [$];
  exp_rd_t    rd_q    [$];
  logic [1:0] err_q   [$];

  msg_slot_sched_if #(.NUM_SLOTS(8), .ADDR_WIDTH(10), .TAG_W(4)) bus ();

  msg_slot_sched #(
    .NUM_SLOTS (8), .SLOT_BEATS (128), .ADDR_WIDTH (10), .TAG_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0; bus.alloc_tag  = '0;
    bus.cmpl_valid  = 1'b0; bus.cmpl_tag   = '0; bus.cmpl_beats = '0;
    bus.rd_ready    = 1'b0;
    bus.rel_valid   = 1'b0; bus.rel_tag    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++;
    if ({bus.alloc_ready, bus.alloc_done, bus.rd_valid, bus.err, bus.err_code} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.alloc_ready, bus.alloc_done, bus.rd_valid, bus.err, bus.err_code});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.alloc_ready, bus.free_cnt} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL reset_free: ready=%b free_cnt=%0d expected 1/8", bus.alloc_ready, bus.free_cnt);
    end
  endtask

  task automatic test_basic_alloc();
    logic [3:0] tags [3] = '{4'd3, 4'd5, 4'd7};
    logic [9:0] exp;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_tag   = tags[i];
      alloc_q.push_back(10'(i * 128));
      tick();
      exp = alloc_q.pop_front();
      checks++;
      if ({bus.alloc_done, bus.alloc_base} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL basic_alloc tag %0d: done=%b base=%0d expected 1/%0d",
                 tags[i], bus.alloc_done, bus.alloc_base, exp);
      end
    end
    bus.alloc_valid = 1'b0;
    checks++;
    if (bus.free_cnt !== 4'd5) begin
      errors++;
      $display("FAIL basic_free_cnt: got %0d expected 5", bus.free_cnt);
    end
  endtask

  task automatic test_lifecycle();
    exp_rd_t    exp;
    logic [9:0] expb;
    int         n;
    bus.cmpl_valid = 1'b1; bus.cmpl_tag = 4'd5; bus.cmpl_beats = 8'd16;
    rd_q.push_back(exp_rd_t'{4'd5, 10'd128, 8'd16});
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL cmpl_latency: rd_valid=%b expected 0 one edge after cmpl", bus.rd_valid);
    end
    bus.cmpl_tag = 4'd3; bus.cmpl_beats = 8'd1;
    rd_q.push_back(exp_rd_t'{4'd3, 10'd0, 8'd1});
    tick();
    bus.cmpl_valid = 1'b0;
    n = 0;
    while (!bus.rd_valid && n < 4) begin tick(); n++; end
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_valid_timeout: got %b expected 1", bus.rd_valid);
    end
    tick();
    exp = rd_q[0];
    checks++;
    if ({bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL head_hold: got tag=%0d base=%0d beats=%0d expected %0d/%0d/%0d",
               bus.rd_tag, bus.rd_base, bus.rd_beats, exp.tag, exp.base, exp.beats);
    end
    bus.rd_ready = 1'b1;
    while (rd_q.size() > 0) begin
      exp = rd_q.pop_front();
      checks++;
      if ({bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL fifo_order: got v=%b tag=%0d base=%0d beats=%0d expected %0d/%0d/%0d",
                 bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats, exp.tag, exp.base, exp.beats);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fifo_drained: rd_valid=%b expected 0", bus.rd_valid);
    end
    bus.rel_valid = 1'b1; bus.rel_tag = 4'd5;
    tick();
    bus.rel_valid = 1'b0;
    checks++;
    if ({bus.err, bus.free_cnt} !== {1'b0, 4'd6}) begin
      errors++;
      $display("FAIL release_ok: err=%b free_cnt=%0d expected 0/6", bus.err, bus.free_cnt);
    end
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd9;
    alloc_q.push_back(10'd128);
    tick();
    bus.alloc_valid = 1'b0;
    expb = alloc_q.pop_front();
    checks++;
    if ({bus.alloc_done, bus.alloc_base, bus.free_cnt} !== {1'b1, expb, 4'd5}) begin
      errors++;
      $display("FAIL realloc: done=%b base=%0d free=%0d expected 1/%0d/5",
               bus.alloc_done, bus.alloc_base, bus.free_cnt, expb);
    end
  endtask

  task automatic test_dup_alloc();
    logic [9:0] expb;
    logic [1:0] expc;
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd11;
    alloc_q.push_back(10'd384);
    tick();
    expb = alloc_q.pop_front();
    checks++;
    if ({bus.alloc_done, bus.alloc_base} !== {1'b1, expb}) begin
      errors++;
      $display("FAIL dup_first: done=%b base=%0d expected 1/%0d", bus.alloc_done, bus.alloc_base, expb);
    end
    err_q.push_back(ERR_DUP_ALLOC);
    tick();
    bus.alloc_valid = 1'b0;
    expc = err_q.pop_front();
    checks++;
    if ({bus.err, bus.err_code, bus.alloc_done, bus.free_cnt} !== {1'b1, expc, 1'b0, 4'd4}) begin
      errors++;
      $display("FAIL dup_second: err=%b code=%0d done=%b free=%0d expected 1/%0d/0/4",
               bus.err, bus.err_code, bus.alloc_done, bus.free_cnt, expc);
    end
  endtask

  task automatic test_bad_cmpl();
    logic [3:0] tags  [3] = '{4'd11, 4'd11, 4'd12};
    logic [7:0] beats [3] = '{8'd0, 8'd129, 8'd5};
    logic [1:0] expc;
    exp_rd_t    exp;
    int         n;
    for (int i = 0; i < 3; i++) begin
      bus.cmpl_valid = 1'b1; bus.cmpl_tag = tags[i]; bus.cmpl_beats = beats[i];
      err_q.push_back(ERR_BAD_CMPL);
      tick();
      expc = err_q.pop_front();
      checks++;
      if ({bus.err, bus.err_code} !== {1'b1, expc}) begin
        errors++;
        $display("FAIL bad_cmpl case %0d: err=%b code=%0d expected 1/%0d", i, bus.err, bus.err_code, expc);
      end
    end
    bus.cmpl_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_cmpl_no_push: rd_valid=%b expected 0", bus.rd_valid);
    end
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd11;
    bus.cmpl_valid  = 1'b1; bus.cmpl_tag  = 4'd12; bus.cmpl_beats = 8'd5;
    bus.rel_valid   = 1'b1; bus.rel_tag   = 4'd7;
    err_q.push_back(ERR_DUP_ALLOC);
    tick();
    idle_inputs();
    expc = err_q.pop_front();
    checks++;
    if ({bus.err, bus.err_code} !== {1'b1, expc}) begin
      errors++;
      $display("FAIL err_priority: err=%b code=%0d expected 1/%0d", bus.err, bus.err_code, expc);
    end
    bus.cmpl_valid = 1'b1; bus.cmpl_tag = 4'd11; bus.cmpl_beats = 8'd128;
    rd_q.push_back(exp_rd_t'{4'd11, 10'd384, 8'd128});
    tick();
    bus.cmpl_valid = 1'b0;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL cmpl_max_beats: err=%b expected 0", bus.err);
    end
    n = 0;
    while (!bus.rd_valid && n < 4) begin tick(); n++; end
    exp = rd_q.pop_front();
    checks++;
    if ({bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL max_beats_entry: v=%b tag=%0d base=%0d beats=%0d expected %0d/%0d/%0d",
               bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats, exp.tag, exp.base, exp.beats);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_full_pool();
    logic [9:0] expb;
    logic [1:0] expc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1; bus.alloc_tag = 4'(i);
      alloc_q.push_back(10'(i * 128));
      tick();
      expb = alloc_q.pop_front();
      checks++;
      if ({bus.alloc_done, bus.alloc_base} !== {1'b1, expb}) begin
        errors++;
        $display("FAIL full_alloc tag %0d: done=%b base=%0d expected 1/%0d",
                 i, bus.alloc_done, bus.alloc_base, expb);
      end
    end
    bus.alloc_valid = 1'b0;
    checks++;
    if ({bus.alloc_ready, bus.free_cnt} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL pool_empty: ready=%b free=%0d expected 0/0", bus.alloc_ready, bus.free_cnt);
    end
    bus.rel_valid = 1'b1; bus.rel_tag = 4'd2;
    err_q.push_back(ERR_BAD_REL);
    tick();
    bus.rel_valid = 1'b0;
    expc = err_q.pop_front();
    checks++;
    if ({bus.err, bus.err_code, bus.free_cnt} !== {1'b1, expc, 4'd0}) begin
      errors++;
      $display("FAIL rel_filling: err=%b code=%0d free=%0d expected 1/%0d/0",
               bus.err, bus.err_code, bus.free_cnt, expc);
    end
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd8;
    tick();
    tick();
    bus.alloc_valid = 1'b0;
    checks++;
    if ({bus.alloc_done, bus.err, bus.free_cnt} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL alloc_held_off: done=%b err=%b free=%0d expected 0/0/0",
               bus.alloc_done, bus.err, bus.free_cnt);
    end
  endtask

  task automatic test_same_cycle();
    exp_rd_t    exp;
    logic [9:0] expb;
    int         n;
    bus.cmpl_valid = 1'b1; bus.cmpl_tag = 4'd0; bus.cmpl_beats = 8'd4;
    rd_q.push_back(exp_rd_t'{4'd0, 10'd0, 8'd4});
    tick();
    bus.cmpl_valid = 1'b0;
    n = 0;
    while (!bus.rd_valid && n < 4) begin tick(); n++; end
    exp = rd_q.pop_front();
    checks++;
    if ({bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL same_head: v=%b tag=%0d base=%0d beats=%0d expected %0d/%0d/%0d",
               bus.rd_valid, bus.rd_tag, bus.rd_base, bus.rd_beats, exp.tag, exp.base, exp.beats);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd9;
    bus.rel_valid   = 1'b1; bus.rel_tag   = 4'd0;
    tick();
    bus.rel_valid = 1'b0;
    checks++;
    if ({bus.alloc_done, bus.alloc_ready, bus.free_cnt} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL rel_alloc_same: done=%b ready=%b free=%0d expected 0/1/1",
               bus.alloc_done, bus.alloc_ready, bus.free_cnt);
    end
    alloc_q.push_back(10'd0);
    tick();
    bus.alloc_valid = 1'b0;
    expb = alloc_q.pop_front();
    checks++;
    if ({bus.alloc_done, bus.alloc_base, bus.free_cnt} !== {1'b1, expb, 4'd0}) begin
      errors++;
      $display("FAIL alloc_after_rel: done=%b base=%0d free=%0d expected 1/%0d/0",
               bus.alloc_done, bus.alloc_base, bus.free_cnt, expb);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] expb;
    bus.cmpl_valid = 1'b1; bus.cmpl_tag = 4'd1; bus.cmpl_beats = 8'd8;
    tick();
    bus.cmpl_valid = 1'b0;
    tick();
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_queue: rd_valid=%b expected 1", bus.rd_valid);
    end
    rst = 1'b1;
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd12;
    bus.rd_ready = 1'b1;
    tick();
    checks++;
    if ({bus.alloc_ready, bus.alloc_done, bus.alloc_base, bus.rd_valid, bus.rd_tag,
         bus.rd_base, bus.rd_beats, bus.err, bus.err_code} !== 40'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b done=%b base=%0d rdv=%b err=%b code=%0d expected all 0",
               bus.alloc_ready, bus.alloc_done, bus.alloc_base, bus.rd_valid, bus.err, bus.err_code);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if ({bus.free_cnt, bus.alloc_ready, bus.rd_valid, bus.err} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset: free=%0d ready=%b rdv=%b err=%b expected 8/1/0/0",
               bus.free_cnt, bus.alloc_ready, bus.rd_valid, bus.err);
    end
    bus.alloc_valid = 1'b1; bus.alloc_tag = 4'd1;
    alloc_q.push_back(10'd0);
    tick();
    bus.alloc_valid = 1'b0;
    expb = alloc_q.pop_front();
    checks++;
    if ({bus.alloc_done, bus.alloc_base, bus.err} !== {1'b1, expb, 1'b0}) begin
      errors++;
      $display("FAIL tag_table_cleared: done=%b base=%0d err=%b expected 1/%0d/0",
               bus.alloc_done, bus.alloc_base, bus.err, expb);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_alloc();
    test_lifecycle();
    test_dup_alloc();
    test_bad_cmpl();
    test_full_pool();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/msg_slot_sched.md
# msg_slot_sched

Buffer-slot scheduler for the PCIe message-assembly SRAM. It divides the 1024×256 assembly SRAM into fixed slots and allocates one slot per message tag when the first fragment arrives. It queues completed messages for the AXI-to-SRAM read side and returns slots to the free pool when the reader releases them. It sits between `pcie_msg_receiver` (allocation and completion requests) and the read path (dequeue and release).

## Interface
- `NUM_SLOTS`, 8: number of SRAM slots; power of two.
- `SLOT_BEATS`, 128: 256-bit beats per slot; `NUM_SLOTS*SLOT_BEATS` ≤ 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 10: SRAM beat-address width.
- `TAG_W`, 4: message tag width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alloc_valid` in 1: allocation request.
- `alloc_tag` in `TAG_W`: tag of the new message.
- `alloc_ready` out 1: a free slot exists.
- `alloc_done` out 1: one-cycle pulse; `alloc_base` is valid.
- `alloc_base` out `ADDR_WIDTH`: beat base address of the granted slot.
- `cmpl_valid` in 1: message fully assembled.
- `cmpl_tag` in `TAG_W`: tag of the completed message.
- `cmpl_beats` in 8: message length in beats, 1..`SLOT_BEATS`.
- `rd_valid` out 1: a completed message is available.
- `rd_ready` in 1: reader accepts the head entry.
- `rd_tag` out `TAG_W`: tag of the head entry.
- `rd_base` out `ADDR_WIDTH`: base address of the head entry.
- `rd_beats` out 8: length of the head entry.
- `rel_valid` in 1: reader has finished with a message.
- `rel_tag` in `TAG_W`: tag of the released message.
- `err` out 1: one-cycle error pulse.
- `err_code` out 2: 1 = duplicate alloc, 2 = bad completion, 3 = bad release.
- `free_cnt` out `$clog2(NUM_SLOTS)+1`: number of free slots.

## Operation
- Each slot is in one of four states: FREE → FILLING (on alloc) → READY (on cmpl) → READING (on rd pop) → FREE (on rel). No other transitions exist.
- A tag table holds `tag_vld[2^TAG_W]` and `tag_slot[2^TAG_W]`. A tag maps to at most one slot.
- Alloc is accepted when `alloc_valid && alloc_ready`.
  - If `tag_vld[alloc_tag]` is set: `err`=1, `err_code`=1, no state change.
  - Otherwise: take the lowest-index FREE slot, set it to FILLING, map the tag, decrement `free_cnt`, pulse `alloc_done`, and drive `alloc_base = slot*SLOT_BEATS`.
- Completion:
  - Rejected with `err_code`=2 and no state change if the tag is unmapped, the slot is not FILLING, or `cmpl_beats` is 0 or greater than `SLOT_BEATS`.
  - Otherwise: the slot goes to READY and {tag, base, beats} is pushed to the ready FIFO.
- Ready FIFO:
  - Depth `NUM_SLOTS`, ordered by completion; it cannot overflow.
  - `rd_valid` = FIFO not empty. The head entry is held stable while `rd_valid && !rd_ready`.
  - A pop sets that slot to READING.
- Release:
  - Rejected with `err_code`=3 if the tag is unmapped or its slot is not READING.
  - Otherwise: the slot goes to FREE, the tag mapping is cleared, and `free_cnt` is incremented.
- Simultaneous events:
  - Alloc, cmpl, pop and rel are all processed in the same cycle.
  - Slot state used for decisions is the state at the start of the cycle. A slot released in cycle N cannot be granted until cycle N+1.
  - `free_cnt` update = −(alloc granted) + (release OK), net applied.
  - When more than one error occurs in a cycle, the reported `err_code` priority is 1 > 2 > 3.
- Reset: all slots FREE, tag table cleared, FIFO emptied, `free_cnt`=`NUM_SLOTS`. All other outputs are 0, including `alloc_ready` while `rst`=1. Reset mid-operation discards all in-flight messages with no error reported.

## Timing
- `alloc_ready` = !`rst` && `free_cnt`≠0. It is derived only from registered state; there is no path from `alloc_valid`.
- `alloc_done`, `alloc_base` and `err` are registered and appear one cycle after the accepting edge.
- Completion to `rd_valid`: one cycle (cmpl at edge N → `rd_valid` after edge N+1).
- Pop at edge N → the next head entry, if any, is visible after edge N. Back-to-back pops are allowed.
- Release at edge N → `free_cnt` and `alloc_ready` are updated after edge N.

## Structure
- Package `msg_slot_pkg` holds:
  - the slot-state enum (FREE, FILLING, READY, READING);
  - the `err_code` constants;
  - the ready-entry struct {tag, base, beats}.
- Sub-module `msg_slot_fifo`: synchronous FIFO with parameterised width and depth, full/empty flags, and a registered read pointer.
- The top level contains the state array, tag table, priority encoder and error logic.

## Test plan
- **Basic allocation after reset:** alloc tags 3, 5, 7 on consecutive cycles → `alloc_base` = 0, 128, 256; `free_cnt` = 5.
- **Full pool:** alloc tags 0..7 with `rd_ready`=0 → `alloc_ready`=0 and `free_cnt`=0. Release of any tag → `err_code`=3 (slots are FILLING). Alloc tag 8 is held off and not accepted.
- **Full lifecycle:** cmpl tag 5 with 16 beats, then cmpl tag 3 with 1 beat → FIFO order tag 5 (base 128, 16 beats) then tag 3 (base 0, 1 beat). Pop both, release tag 5 → the next alloc gets base 128.
- **Duplicate alloc:** alloc tag 3 twice → `err_code`=1 on the second; `free_cnt` drops by only 1.
- **Bad completions:** cmpl with `cmpl_beats`=0, with 129, and for an unmapped tag → `err_code`=2 each time; no FIFO push.
- **Same-cycle edge cases and reset:**
  - Release and alloc in the same cycle with `free_cnt`=0 → alloc is not accepted; it is accepted the next cycle and gets the released slot.
  - Assert `rst` mid-burst → all outputs 0; `free_cnt`=8 one cycle after `rst` falls.
